firebird7_in_gate1_tessent_tdr_w19_30: RTL and testbench
========================================================

FIREBIRD7_IN_GATE1_TESSENT_TDR_W19_30 -- requirements
Module: firebird7_in_gate1_tessent_tdr_w19_30

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
- ijtag_tck  in  1  sole clock; all state updates on the rising edge.
- ijtag_reset  in  1  synchronous, active-high reset.
REQ-002 The block SHALL expose the IJTAG control ports:
- ijtag_sel  in  1  TDR selected on the active scan path.
- ijtag_ce  in  1  capture enable.
- ijtag_se  in  1  shift enable.
- ijtag_ue  in  1  update enable.
- ijtag_si  in  1  scan in.
- ijtag_so  out  1  scan out.
REQ-003 The block SHALL expose the data ports:
- capture_data_in  in  19  functional observe value.
- ijtag_data_out  out  19  update-register data, drives the downstream data mux ijtag_data_in.
- ijtag_select  out  1  update-register select bit, drives the downstream mux ijtag_select.
REQ-004 The block SHALL have no parameters; widths come from the shared package.

Function
REQ-005 The block SHALL hold a 20-bit shift register sr[19:0], where sr[19] is the select bit and sr[18:0] is data.
REQ-006 The block SHALL hold a 20-bit update register ur[19:0]; ijtag_select = ur[19] and ijtag_data_out = ur[18:0].
REQ-007 The shift register SHALL operate as follows:
- Capture: sel&ce&!rst loads sr in the same edge.
- Shift: sel&se&!ce shifts right: sr <= {ijtag_si, sr[19:1]}.
- Otherwise sr holds.
REQ-008 When ce and se are both high, capture SHALL take priority and no shift SHALL occur that cycle.
REQ-009 ijtag_so SHALL equal sr[0] combinationally from the register; zero latency from sr.
REQ-010 Update: sel&ue SHALL load ur <= sr on that edge.
REQ-011 When ue is coincident with ce or se, ur SHALL load the pre-edge sr value.
REQ-012 When sel=0, sr and ur SHALL hold regardless of ce/se/ue.
REQ-013 A full shift SHALL take 20 shift cycles; bit sr[0] SHALL exit first (LSB-first).
REQ-014 The control sequence SHALL be modelled as a three-state FSM:
- States: IDLE, SHIFTING, UPDATED.
- IDLE->SHIFTING on sel&se.
- SHIFTING->UPDATED on sel&ue.
- Any->IDLE on sel&ce.
- UPDATED->SHIFTING on sel&se.
- The state is internal and affects no outputs; it exists for coverage and assertions.

Reset
REQ-015 Reset SHALL be sampled only on the rising edge of ijtag_tck; no asynchronous path.
REQ-016 Reset values SHALL be: sr=0, ur=0, state=IDLE, so ijtag_select=0 (functional path), ijtag_data_out=19'h0, ijtag_so=0.
REQ-017 Reset SHALL override ce/se/ue in the same cycle, including mid-shift; a partially shifted value SHALL be discarded.

Configuration
REQ-018 The macro FIREBIRD7_TDR_CAPTURE_EN SHALL select the capture source:
- Defined: capture loads sr <= {ur[19], capture_data_in}.
- Undefined: capture loads sr <= ur (readback of the update register), and capture_data_in remains a port but is unused.

Structure
REQ-019 The shared package firebird7_in_gate1_tdr_pkg SHALL contain:
- TDR_DATA_W=19.
- TDR_LEN=20.
- TDR_SEL_BIT=19.
- TDR_RESET_VAL=20'h0.
- The FSM state enum tdr_state_e {IDLE, SHIFTING, UPDATED}.
REQ-020 One sub-module, firebird7_in_gate1_tdr_bit (one shift flop plus one update flop with capture/shift/update muxing), SHALL be instantiated 20 times; all other logic is inline.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset: assert ijtag_reset 2 cycles -> ijtag_select=0, ijtag_data_out=0, ijtag_so=0.
- Shift and update: shift 20'h8_1234 LSB-first (20 se cycles), then 1 ue cycle -> ijtag_select=1, ijtag_data_out=19'h01234; ur unchanged during shifting.
- Capture with CAPTURE_EN: capture_data_in=19'h5A5A5, ur[19]=1, ce for 1 cycle, then 20 shifts -> ijtag_so streams 20'hDA5A5 LSB-first; without the macro the stream equals the current ur.
- ce&se together for 1 cycle with capture_data_in=19'h7FFFF -> capture only, no shift (CAPTURE_EN defined).
- sel=0 with ce/se/ue toggling for 30 cycles -> sr, ur and ijtag_so unchanged.
- ijtag_reset after 7 of 20 shifts -> sr=0, ur=0; a following full 20'h00003 shift plus update yields ijtag_select=0, data=19'h3.

Source files
------------

// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// firebird7_in_gate1_tdr_pkg: shared widths, reset value and control-FSM state type for the 20-bit IJTAG TDR
package firebird7_in_gate1_tdr_pkg;
  localparam int TDR_DATA_W = 19;
  localparam int TDR_LEN = 20;
  localparam int TDR_SEL_BIT = 19;
  localparam logic [TDR_LEN-1:0] TDR_RESET_VAL = 20'h0;
  typedef enum logic [1:0] {IDLE, SHIFTING, UPDATED} tdr_state_e;
endpackage

// File: rtl/firebird7_in_gate1_tdr_bit.sv
// firebird7_in_gate1_tdr_bit: one TDR cell, a shift flop plus an update flop with capture/shift/update muxing
// Ports: i_clk/i_rst clock and sync reset; i_cap, i_shift, i_upd qualified enables;
//        i_cap_val capture value, i_si serial in; o_sr shift flop, o_ur update flop.
module firebird7_in_gate1_tdr_bit
  import firebird7_in_gate1_tdr_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cap,
  input  logic i_shift,
  input  logic i_upd,
  input  logic i_cap_val,
  input  logic i_si,
  output logic o_sr,
  output logic o_ur
);
  logic r_sr, r_ur;
  // capture wins over shift; update samples the pre-edge shift flop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr <= RST_VAL;
      r_ur <= RST_VAL;
    end else begin
      r_sr <= i_cap ? i_cap_val : i_shift ? i_si : r_sr;
      if (i_upd) r_ur <= r_sr;
    end
  end
  assign o_sr = r_sr;
  assign o_ur = r_ur;
endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_30.sv
// firebird7_in_gate1_tessent_tdr_w19_30: 20-bit IJTAG TDR, bit 19 drives the downstream mux select, bits 18:0 its data
// Ports: ijtag_tck clock, ijtag_reset sync active-high reset; ijtag_sel/ce/se/ue/si control and scan in;
//        ijtag_so scan out; capture_data_in observe value; ijtag_data_out/ijtag_select update-register outputs.
// Macro FIREBIRD7_TDR_CAPTURE_EN: capture loads {ur[19], capture_data_in}; otherwise capture reads back ur.
module firebird7_in_gate1_tessent_tdr_w19_30
  import firebird7_in_gate1_tdr_pkg::*;
(
  input  logic                  ijtag_tck,
  input  logic                  ijtag_reset,
  input  logic                  ijtag_sel,
  input  logic                  ijtag_ce,
  input  logic                  ijtag_se,
  input  logic                  ijtag_ue,
  input  logic                  ijtag_si,
  input  logic [TDR_DATA_W-1:0] capture_data_in,
  output logic                  ijtag_so,
  output logic [TDR_DATA_W-1:0] ijtag_data_out,
  output logic                  ijtag_select
);
  logic [TDR_LEN-1:0] w_sr, w_ur, w_cap, w_sin;
  tdr_state_e r_state, w_state_nxt;
`ifdef FIREBIRD7_TDR_CAPTURE_EN
  assign w_cap = {w_ur[TDR_SEL_BIT], capture_data_in};
`else
  logic w_unused;
  assign w_cap = w_ur;
  assign w_unused = ^capture_data_in;
`endif
  // shift right: ijtag_si enters at the select bit, sr[0] leaves on ijtag_so
  assign w_sin = {ijtag_si, w_sr[TDR_LEN-1:1]};
  for (genvar b = 0; b < TDR_LEN; b++) begin : g_bit
    firebird7_in_gate1_tdr_bit #(.RST_VAL(TDR_RESET_VAL[b])) u_bit (
      .i_clk    (ijtag_tck),
      .i_rst    (ijtag_reset),
      .i_cap    (ijtag_sel & ijtag_ce),
      .i_shift  (ijtag_sel & ijtag_se),
      .i_upd    (ijtag_sel & ijtag_ue),
      .i_cap_val(w_cap[b]),
      .i_si     (w_sin[b]),
      .o_sr     (w_sr[b]),
      .o_ur     (w_ur[b])
    );
  end
  assign ijtag_so = w_sr[0];
  assign ijtag_select = w_ur[TDR_SEL_BIT];
  assign ijtag_data_out = w_ur[TDR_DATA_W-1:0];
  // control-sequence tracker; observable only through assertions/coverage
  always_comb begin
    w_state_nxt = !ijtag_sel ? r_state :
                  ijtag_ce ? IDLE :
                  (ijtag_se && r_state != SHIFTING) ? SHIFTING :
                  (ijtag_ue && r_state == SHIFTING) ? UPDATED : r_state;
  end
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_30.sv
// tb_firebird7_in_gate1_tessent_tdr_w19_30: directed self-checking bench for the 20-bit IJTAG TDR
module tb_firebird7_in_gate1_tessent_tdr_w19_30;
  logic tck = 1'b0;
  logic rst, sel, ce, se, ue, si;
  logic [18:0] cdi;
  logic so, select;
  logic [18:0] data_out;
  int checks = 0;
  int errors = 0;

  firebird7_in_gate1_tessent_tdr_w19_30 dut (
    .ijtag_tck      (tck),
    .ijtag_reset    (rst),
    .ijtag_sel      (sel),
    .ijtag_ce       (ce),
    .ijtag_se       (se),
    .ijtag_ue       (ue),
    .ijtag_si       (si),
    .capture_data_in(cdi),
    .ijtag_so       (so),
    .ijtag_data_out (data_out),
    .ijtag_select   (select)
  );

  always #5 tck = ~tck;

  task automatic shift_word(input logic [19:0] v, output logic [19:0] out);
    for (int i = 0; i < 20; i++) begin
      @(negedge tck);
      out[i] = so;
      sel = 1'b1;
      se = 1'b1;
      si = v[i];
    end
    @(negedge tck);
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic update();
    @(negedge tck);
    sel = 1'b1;
    ue = 1'b1;
    @(negedge tck);
    ue = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge tck);
    checks++;
    if (select !== 1'b0) begin errors++; $display("FAIL reset_select got %0b want 0", select); end
    checks++;
    if (data_out !== 19'h0) begin errors++; $display("FAIL reset_data got %h want 00000", data_out); end
    checks++;
    if (so !== 1'b0) begin errors++; $display("FAIL reset_so got %0b want 0", so); end
    rst = 1'b0;
  endtask

  task automatic test_shift_update();
    logic [19:0] v = 20'h81234;
    for (int i = 0; i < 20; i++) begin
      @(negedge tck);
      checks++;
      if ({select, data_out} !== 20'h0) begin
        errors++; $display("FAIL ur_during_shift cycle %0d got %h want 00000", i, {select, data_out});
      end
      sel = 1'b1;
      se = 1'b1;
      si = v[i];
    end
    @(negedge tck);
    se = 1'b0;
    checks++;
    if ({select, data_out} !== 20'h0) begin errors++; $display("FAIL ur_after_shift got %h want 00000", {select, data_out}); end
    update();
    checks++;
    if (select !== 1'b1) begin errors++; $display("FAIL update_select got %0b want 1", select); end
    checks++;
    if (data_out !== 19'h01234) begin errors++; $display("FAIL update_data got %h want 01234", data_out); end
  endtask

  task automatic test_capture();
    logic [19:0] got;
    logic [19:0] exp;
`ifdef FIREBIRD7_TDR_CAPTURE_EN
    exp = 20'hDA5A5;
`else
    exp = 20'h81234;
`endif
    @(negedge tck);
    cdi = 19'h5A5A5;
    sel = 1'b1;
    ce = 1'b1;
    @(negedge tck);
    ce = 1'b0;
    shift_word(20'h0, got);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL capture_stream got %h want %h", got, exp); end
    checks++;
    if ({select, data_out} !== 20'h81234) begin errors++; $display("FAIL capture_ur got %h want 81234", {select, data_out}); end
  endtask

  task automatic test_ce_se();
    logic [19:0] got;
    logic [19:0] exp;
`ifdef FIREBIRD7_TDR_CAPTURE_EN
    exp = 20'hFFFFF;
`else
    exp = 20'h81234;
`endif
    @(negedge tck);
    cdi = 19'h7FFFF;
    sel = 1'b1;
    ce = 1'b1;
    se = 1'b1;
    si = 1'b0;
    @(negedge tck);
    ce = 1'b0;
    se = 1'b0;
    checks++;
    if (so !== exp[0]) begin errors++; $display("FAIL ce_se_so got %0b want %0b", so, exp[0]); end
    shift_word(20'h0, got);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ce_se_stream got %h want %h", got, exp); end
  endtask

  task automatic test_sel_off();
    logic [19:0] got;
    shift_word(20'hA5F0C, got);
    for (int i = 0; i < 30; i++) begin
      @(negedge tck);
      checks++;
      if ({so, select, data_out} !== {1'b0, 20'h81234}) begin
        errors++; $display("FAIL sel_off cycle %0d got so=%0b ur=%h want so=0 ur=81234", i, so, {select, data_out});
      end
      sel = 1'b0;
      ce = i[0];
      se = i[1];
      ue = i[2];
      si = i[3];
    end
    @(negedge tck);
    ce = 1'b0;
    se = 1'b0;
    ue = 1'b0;
    si = 1'b0;
    shift_word(20'h0, got);
    checks++;
    if (got !== 20'hA5F0C) begin errors++; $display("FAIL sel_off_sr got %h want a5f0c", got); end
    checks++;
    if ({select, data_out} !== 20'h81234) begin errors++; $display("FAIL sel_off_ur got %h want 81234", {select, data_out}); end
  endtask

  task automatic test_reset_midshift();
    logic [19:0] got;
    shift_word(20'hFFFFF, got);
    for (int i = 0; i < 7; i++) begin
      @(negedge tck);
      sel = 1'b1;
      se = 1'b1;
      si = 1'b1;
    end
    @(negedge tck);
    rst = 1'b1;
    @(negedge tck);
    rst = 1'b0;
    se = 1'b0;
    si = 1'b0;
    checks++;
    if (so !== 1'b0) begin errors++; $display("FAIL midshift_so got %0b want 0", so); end
    checks++;
    if ({select, data_out} !== 20'h0) begin errors++; $display("FAIL midshift_ur got %h want 00000", {select, data_out}); end
    shift_word(20'h00003, got);
    checks++;
    if (got !== 20'h0) begin errors++; $display("FAIL midshift_sr got %h want 00000", got); end
    update();
    checks++;
    if (select !== 1'b0) begin errors++; $display("FAIL post_reset_select got %0b want 0", select); end
    checks++;
    if (data_out !== 19'h3) begin errors++; $display("FAIL post_reset_data got %h want 00003", data_out); end
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    ce = 1'b0;
    se = 1'b0;
    ue = 1'b0;
    si = 1'b0;
    cdi = 19'h0;
    test_reset();
    test_shift_update();
    test_capture();
    test_ce_se();
    test_sel_off();
    test_reset_midshift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
